button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Upstream conditioning stage for push-button and switch inputs. Its debounced level output `btn_out` drives the `src` input of the one-shot pulse generator.
- Synchronises the raw asynchronous pin into the `clk` domain.
- Accepts a level change only after the synchronised input has held steady for STABLE_CYCLES consecutive clocks.
- Outputs a clean, glitch-free level plus a busy flag. The downstream one-shot then sees exactly one rising edge per physical press.

Parameters:
- STABLE_CYCLES, 1000000: consecutive stable synchronised samples required to accept a new level (10 ms at 100 MHz). Legal range 2 to 2^CNT_W.
- CNT_W, 20: width of the stability counter.
- SYNC_STAGES, 2: flip-flop stages in the input synchroniser. Legal range 2 to 4.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- btn_in  input  1  raw button/switch pin, asynchronous to clk, may bounce.
- btn_out  output  1  debounced level; connects to the pulse generator's src.
- busy  output  1  high while a candidate level change is being qualified.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - all synchroniser flops to 0;
  - state to S_LOW;
  - counter to 0;
  - btn_out=0 and busy=0.
- Release of reset is assumed synchronous to clk at system level. No release-side synchroniser is built here.
- Synchroniser: a SYNC_STAGES-deep flop chain. sync_in is the last stage. No logic is permitted between stages.
- State machine, with 2-bit encoding and the counter cnt (CNT_W bits):
  - S_LOW: btn_out=0, busy=0. If sync_in=1, go to S_RISE and set cnt=0.
  - S_RISE: btn_out=0, busy=1.
    - If sync_in=0, return to S_LOW and set cnt=0 (abort, no output change).
    - Else if cnt==STABLE_CYCLES-1, go to S_HIGH and set cnt=0.
    - Else cnt=cnt+1.
  - S_HIGH: btn_out=1, busy=0. If sync_in=0, go to S_FALL and set cnt=0.
  - S_FALL: btn_out=1, busy=1.
    - If sync_in=1, return to S_HIGH and set cnt=0.
    - Else if cnt==STABLE_CYCLES-1, go to S_LOW and set cnt=0.
    - Else cnt=cnt+1.
  - Unused encodings go to S_LOW with cnt=0.
- Outputs are decoded from the registered state only (Moore). There is no combinational path from btn_in to btn_out.
- Latency: a clean level change sampled at clock edge 0 appears on btn_out after SYNC_STAGES+STABLE_CYCLES+1 edges. This is 7 edges with SYNC_STAGES=2, STABLE_CYCLES=4.
- Glitch rejection: any synchronised excursion shorter than STABLE_CYCLES+1 cycles leaves btn_out unchanged. Each bounce restarts qualification from cnt=0.
- The counter never wraps. It is cleared on every state entry and compared for equality only.
- Reset during S_RISE or S_FALL discards the in-progress qualification: btn_out=0 immediately.
- btn_in held high through reset release:
  - btn_out stays 0 until full qualification completes;
  - it then rises once, and downstream sees one press.
- btn_out toggles at most once per STABLE_CYCLES+1 clocks.

Decomposition:
- Shared package holds:
  - the state encoding constants S_LOW=2'b00, S_RISE=2'b01, S_HIGH=2'b11, S_FALL=2'b10;
  - the default debounce constant for the board clock.
- The synchroniser is a natural sub-module: sync_ff, parameterised by SYNC_STAGES, with ports clk, reset, d, q. Other clock-domain inputs in the design (UART RX, SPI MISO, I2C SDA/SCL) reuse it.

Test Plan:
- Parameters for all scenarios: STABLE_CYCLES=4, SYNC_STAGES=2.
- Clean press: after reset, btn_in 0->1 held 20 cycles -> busy=1 from edge 3 to edge 6; btn_out=1 at edge 7 and stays 1; busy=0 from edge 7.
- Bouncing press: btn_in toggles 1,0,1,0 every 2 cycles, then holds 1 -> btn_out stays 0 through the bounce; rises exactly 7 edges after the final 0->1; exactly one rising edge on btn_out.
- Short glitch: btn_out=1 steady, btn_in pulses 0 for 3 cycles -> btn_out remains 1; busy pulses high then returns to 0; state returns to S_HIGH.
- Release: btn_out=1, btn_in 1->0 held -> btn_out=0 at edge 7 after the change; btn_out high for exactly the qualified duration.
- Reset mid-qualification: btn_in=1, reset driven 0 at cycle 5 (state S_RISE, cnt=2) asynchronously between edges -> btn_out=0 and busy=0 immediately. After release with btn_in still 1, btn_out rises 7 edges later.
- Downstream check: btn_out connected to the pulse generator's src, btn_in bounces 5 times then holds 1 for 50 cycles -> exactly one 1-cycle pulse on the generator output.

Source files
------------

// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: state encoding and board-clock defaults.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    S_RISE = 2'b01,
    S_HIGH = 2'b11,
    S_FALL = 2'b10
  } state_e;

  // 10 ms of stability at the 100 MHz board clock
  localparam int unsigned DEFAULT_STABLE_CYCLES = 1000000;
  localparam int unsigned DEFAULT_CNT_W         = 20;
  localparam int unsigned DEFAULT_SYNC_STAGES   = 2;

endpackage

// File: rtl/sync_ff.sv
// Plain flop-chain synchroniser for asynchronous single-bit inputs; q is the last stage.
module sync_ff
  import button_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw button pin: accepts a new level only after it has been stable
// for STABLE_CYCLES consecutive synchronised samples.
//
//   state  | meaning
//   S_LOW  | output low, input agrees
//   S_RISE | output low, qualifying a high input
//   S_HIGH | output high, input agrees
//   S_FALL | output high, qualifying a low input
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_W         = DEFAULT_CNT_W,
  parameter int unsigned SYNC_STAGES   = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_out,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             w_sync_in;
  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (btn_in),
    .q    (w_sync_in)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter is cleared on every state change so it never needs to wrap
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LOW: begin
        if (w_sync_in) begin
          w_state_nxt = S_RISE;
          w_cnt_nxt   = '0;
        end
      end
      S_RISE: begin
        if (!w_sync_in) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HIGH: begin
        if (!w_sync_in) begin
          w_state_nxt = S_FALL;
          w_cnt_nxt   = '0;
        end
      end
      S_FALL: begin
        if (w_sync_in) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    btn_out = 1'b0;
    busy    = 1'b0;
    case (r_state)
      S_RISE:  busy = 1'b1;
      S_HIGH:  btn_out = 1'b1;
      S_FALL: begin
        btn_out = 1'b1;
        busy    = 1'b1;
      end
      default: begin
        btn_out = 1'b0;
        busy    = 1'b0;
      end
    endcase
  end

endmodule
